instr_fetch: RTL

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch.sv | 117 +++++++++++
 1 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch unit: FETCH/ISSUE/HALT sequencer with redirect priority and stall hold.
// Define IFETCH_ICOUNT_EN to add the 16-bit issued-instruction counter port icount.
module instr_fetch #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_rdata,
    input  logic        imem_ack,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic [15:0] instr,
    output logic [3:0]  opcode,
    output logic [3:0]  func,
    output logic        instr_valid,
    output logic [15:0] pc,
`ifdef IFETCH_ICOUNT_EN
    output logic [15:0] icount,
`endif
    output logic        halted
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        ISSUE = 2'd1,
        HALT  = 2'd2
    } state_t;

    localparam logic [3:0] HALT_OPCODE = 4'b1111;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] pc_nxt;
    logic [15:0] instr_nxt;
    logic        issue_done;
    logic        req_en;

    // req_en keeps imem_req low until the first clock edge after reset release,
    // so no request (and no ack) is honoured while reset is still settling.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= FETCH;
            pc     <= RESET_PC;
            instr  <= 16'h0000;
            req_en <= 1'b0;
        end else begin
            state  <= state_nxt;
            pc     <= pc_nxt;
            instr  <= instr_nxt;
            req_en <= 1'b1;
        end
    end

    // Redirect outranks ack, stall and halt decode in both active states.
    always_comb begin
        state_nxt  = state;
        pc_nxt     = pc;
        instr_nxt  = instr;
        issue_done = 1'b0;
        unique case (state)
            FETCH: begin
                if (redirect) begin
                    pc_nxt = {redirect_pc[15:1], 1'b0};
                end else if (imem_ack && req_en) begin
                    instr_nxt = imem_rdata;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (redirect) begin
                    pc_nxt     = {redirect_pc[15:1], 1'b0};
                    state_nxt  = FETCH;
                    issue_done = 1'b1;
                end else if (!stall) begin
                    issue_done = 1'b1;
                    if (instr[15:12] == HALT_OPCODE) begin
                        state_nxt = HALT;
                    end else begin
                        pc_nxt    = pc + 16'd2;
                        state_nxt = FETCH;
                    end
                end
            end
            HALT: begin
                state_nxt = HALT;
            end
            default: begin
                state_nxt = FETCH;
            end
        endcase
    end

    assign imem_req    = (state == FETCH) && req_en;
    assign imem_addr   = pc;
    assign instr_valid = (state == ISSUE);
    assign halted      = (state == HALT);
    assign opcode      = instr[15:12];
    assign func        = instr[3:0];

`ifdef IFETCH_ICOUNT_EN
    // Counts every departure from ISSUE; wraps naturally at 16 bits.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            icount <= 16'h0000;
        end else if (issue_done) begin
            icount <= icount + 16'd1;
        end
    end
`else
    logic unused_issue_done;
    assign unused_issue_done = issue_done;
`endif

endmodule
